// File: rtl/irq_controller_if.sv
// Request/acknowledge handshake between the interrupt controller (master)
// and the fetch/interrupt-injection logic (slave).
interface irq_controller_if #(
  parameter int unsigned IDX_W = 2
);
  logic             irq_req;
  logic [IDX_W-1:0] irq_idx;
  logic [31:0]      irq_vector;
  logic             ack;
  logic             reti;

  modport master (
    output irq_req,
    output irq_idx,
    output irq_vector,
    input  ack,
    input  reti
  );

  modport slave (
    input  irq_req,
    input  irq_idx,
    input  irq_vector,
    output ack,
    output reti
  );
endinterface

// File: rtl/irq_controller.sv
// Multi-channel interrupt controller: edge/level capture, masking, fixed
// lowest-index priority, committed req/ack handshake and in-service tracking.
module irq_controller #(
  parameter int unsigned N_IRQ      = 4,
  parameter int unsigned IDX_W      = 2,
  parameter bit          NESTING    = 1'b1,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0010,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0002
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic [N_IRQ-1:0]    edge_mode,
  input  logic [N_IRQ-1:0]    mask_in,
  input  logic                global_en,
  irq_controller_if.master    bus,
  output logic [N_IRQ-1:0]    pending,
  output logic [N_IRQ-1:0]    in_service,
  output logic                busy
);

  localparam logic [N_IRQ-1:0] ONE_N = N_IRQ'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [31:0]      vec_q, vec_d;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic             busy_q;

  logic [N_IRQ-1:0] rise_s;
  logic [N_IRQ-1:0] base_s;
  logic [N_IRQ-1:0] eligible_s;
  logic [N_IRQ-1:0] ack_clr_s;
  logic [N_IRQ-1:0] reti_clr_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             ack_take_s;

  // Isolates the lowest set bit; zero input yields zero.
  function automatic logic [N_IRQ-1:0] lowest_bit(input logic [N_IRQ-1:0] v);
    return v & (~v + ONE_N);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [31:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_BASE + (32'(idx) * VEC_STRIDE);
  endfunction

  assign rise_s    = irq_in & ~irq_prev_q;
  assign win_idx_s = lowest_idx(eligible_s);

  // Eligibility: enabled pending channels not in service, nesting-restricted.
  always_comb begin
    base_s = pending_q & mask_in & ~in_service_q & {N_IRQ{global_en}};
    if (NESTING) begin
      // lowest_bit - 1 selects every channel strictly above in priority; all ones when idle.
      eligible_s = base_s & (lowest_bit(in_service_q) - ONE_N);
    end else begin
      if (|in_service_q) begin
        eligible_s = '0;
      end else begin
        eligible_s = base_s;
      end
    end
  end

  // FSM next state: latch the winner in IDLE, hold it committed in REQ until ack.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    vec_d      = vec_q;
    ack_take_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d   = ST_REQ;
          sel_idx_d = win_idx_s;
          vec_d     = vec_of(win_idx_s);
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.ack) begin
          ack_take_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending and in-service next state; reti uses pre-edge in_service, ack OR-ed after.
  always_comb begin
    if (ack_take_s) begin
      ack_clr_s = ONE_N << sel_idx_q;
    end else begin
      ack_clr_s = '0;
    end
    if (bus.reti) begin
      reti_clr_s = lowest_bit(in_service_q);
    end else begin
      reti_clr_s = '0;
    end
    in_service_d = (in_service_q & ~reti_clr_s) | ack_clr_s;
    pending_d    = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_mode[i]) begin
        pending_d[i] = rise_s[i] | (pending_q[i] & ~ack_clr_s[i]);
      end else begin
        pending_d[i] = irq_in[i];
      end
    end
  end

  // State registers; irq_prev keeps tracking irq_in through reset.
  always_ff @(posedge clk) begin
    irq_prev_q <= irq_in;
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_idx_q    <= '0;
      vec_q        <= VEC_BASE;
      pending_q    <= '0;
      in_service_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_idx_q    <= sel_idx_d;
      vec_q        <= vec_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      busy_q       <= |in_service_d;
    end
  end

  assign bus.irq_req    = (state_q == ST_REQ);
  assign bus.irq_idx    = sel_idx_q;
  assign bus.irq_vector = vec_q;
  assign pending        = pending_q;
  assign in_service     = in_service_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: table-driven scoreboard on a nesting instance,
// plus a hand-written sequence on a non-nesting instance.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic [3:0] edge_mode;
  logic [3:0] mask_in;
  logic       global_en;

  logic [3:0] n_pending, n_in_service, f_pending, f_in_service;
  logic       n_busy, f_busy;

  irq_controller_if #(.IDX_W(2)) nbus ();
  irq_controller_if #(.IDX_W(2)) fbus ();

  irq_controller #(.N_IRQ(4), .IDX_W(2), .NESTING(1'b1)) u_nest (
    .clk(clk), .reset(reset), .irq_in(irq_in), .edge_mode(edge_mode),
    .mask_in(mask_in), .global_en(global_en), .bus(nbus),
    .pending(n_pending), .in_service(n_in_service), .busy(n_busy)
  );

  irq_controller #(.N_IRQ(4), .IDX_W(2), .NESTING(1'b0)) u_flat (
    .clk(clk), .reset(reset), .irq_in(irq_in), .edge_mode(edge_mode),
    .mask_in(mask_in), .global_en(global_en), .bus(fbus),
    .pending(f_pending), .in_service(f_in_service), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  em;
    logic [3:0]  mask;
    logic        gen;
    logic        ack;
    logic        reti;
    logic        req;
    logic [1:0]  idx;
    logic [31:0] vec;
    logic [3:0]  pend;
    logic [3:0]  insv;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks;
  int   errors;

  task automatic add(input string n, input logic r, input logic [3:0] i,
                     input logic [3:0] em, input logic [3:0] m, input logic g,
                     input logic a, input logic rt, input logic rq,
                     input logic [1:0] ix, input logic [31:0] v,
                     input logic [3:0] p, input logic [3:0] s);
    vec_t t;
    t.name = n; t.rst = r; t.irq = i; t.em = em; t.mask = m; t.gen = g;
    t.ack = a; t.reti = rt; t.req = rq; t.idx = ix; t.vec = v;
    t.pend = p; t.insv = s;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t e;
    checks = 0;
    errors = 0;
    reset = 1'b1; irq_in = 4'b0000; edge_mode = 4'b1111; mask_in = 4'b1111;
    global_en = 1'b1;
    nbus.ack = 1'b0; nbus.reti = 1'b0; fbus.ack = 1'b0; fbus.reti = 1'b0;

    //   name          rst   irq      em       mask     gen   ack   reti  req   idx    vec           pend     insv
    add("rst",         1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);
    add("e2_cap",      1'b0, 4'b0100, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0100, 4'b0000);
    add("e2_req",      1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h14, 4'b0100, 4'b0000);
    add("e2_ack",      1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h14, 4'b0000, 4'b0100);
    add("e2_reti",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h14, 4'b0000, 4'b0000);
    add("idle",        1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h14, 4'b0000, 4'b0000);
    add("pm_cap",      1'b0, 4'b1010, 4'b1111, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h14, 4'b1010, 4'b0000);
    add("pm_req3",     1'b0, 4'b0000, 4'b1111, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'h16, 4'b1010, 4'b0000);
    add("pm_hold",     1'b0, 4'b0000, 4'b1111, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 32'h16, 4'b1010, 4'b0000);
    add("pm_ack3",     1'b0, 4'b0000, 4'b1111, 4'b1101, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 32'h16, 4'b0010, 4'b1000);
    add("pm_nest1",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12, 4'b0010, 4'b1000);
    add("pm_ack1",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b1010);
    add("pm_reti1",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b1000);
    add("pm_reti3",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b0000);
    add("pm_idle",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b0000);
    add("cm_cap",      1'b0, 4'b0100, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0100, 4'b0000);
    add("cm_req2",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 32'h14, 4'b0100, 4'b0000);
    add("cm_late",     1'b0, 4'b0001, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h14, 4'b0101, 4'b0000);
    add("cm_hold",     1'b0, 4'b0001, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h14, 4'b0101, 4'b0000);
    add("cm_ack2",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h14, 4'b0001, 4'b0100);
    add("sc_req0",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10, 4'b0001, 4'b0100);
    add("sc_ackreti",  1'b0, 4'b0001, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h10, 4'b0001, 4'b0001);
    add("sc_noreq",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0001, 4'b0001);
    add("sc_reti",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h10, 4'b0001, 4'b0000);
    add("sc_rereq",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h10, 4'b0001, 4'b0000);
    add("sc_ack0",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0001);
    add("sc_reti0",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);
    add("sc_idle",     1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);
    add("lv_rst",      1'b1, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);
    add("lv_rel",      1'b0, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0010, 4'b0000);
    add("lv_req1",     1'b0, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12, 4'b0010, 4'b0000);
    add("lv_ack1",     1'b0, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0010, 4'b0010);
    add("lv_noreq",    1'b0, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0010, 4'b0010);
    add("lv_noreq2",   1'b0, 4'b1010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0010, 4'b0010);
    add("lv_drop",     1'b0, 4'b1000, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b0010);
    add("lv_reti",     1'b0, 4'b1000, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b0000);
    add("lv_idle",     1'b0, 4'b1000, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0000, 4'b0000);
    add("rr_cap",      1'b0, 4'b0010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 32'h12, 4'b0010, 4'b0000);
    add("rr_req",      1'b0, 4'b0010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 32'h12, 4'b0010, 4'b0000);
    add("rr_rst",      1'b1, 4'b0010, 4'b1101, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);
    add("rr_after",    1'b0, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h10, 4'b0000, 4'b0000);

    tick();
    for (int k = 0; k < tbl.size(); k++) begin
      v = tbl[k];
      reset = v.rst; irq_in = v.irq; edge_mode = v.em; mask_in = v.mask;
      global_en = v.gen; nbus.ack = v.ack; nbus.reti = v.reti;
      exp_q.push_back(v);
      tick();
      e = exp_q.pop_front();
      check({e.name, ".req"},  32'(nbus.irq_req),    32'(e.req));
      check({e.name, ".idx"},  32'(nbus.irq_idx),    32'(e.idx));
      check({e.name, ".vec"},  nbus.irq_vector,      e.vec);
      check({e.name, ".pend"}, 32'(n_pending),       32'(e.pend));
      check({e.name, ".insv"}, 32'(n_in_service),    32'(e.insv));
      check({e.name, ".busy"}, 32'(n_busy),          32'(|e.insv));
    end
    nbus.ack = 1'b0; nbus.reti = 1'b0;

    // Non-nesting instance: nothing is requested while a channel is in service.
    reset = 1'b1; irq_in = 4'b0000; edge_mode = 4'b1111; mask_in = 4'b1111; global_en = 1'b1;
    tick();
    check("flat_rst.req", 32'(fbus.irq_req), 32'd0);
    check("flat_rst.insv", 32'(f_in_service), 32'd0);
    reset = 1'b0; irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    check("flat_req2.req", 32'(fbus.irq_req), 32'd1);
    check("flat_req2.idx", 32'(fbus.irq_idx), 32'd2);
    fbus.ack = 1'b1;
    tick();
    fbus.ack = 1'b0;
    check("flat_ack2.insv", 32'(f_in_service), 32'h4);
    check("flat_ack2.req", 32'(fbus.irq_req), 32'd0);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    check("flat_cap0.pend", 32'(f_pending), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flat_blocked.req", 32'(fbus.irq_req), 32'd0);
    end
    fbus.reti = 1'b1;
    tick();
    fbus.reti = 1'b0;
    check("flat_reti.insv", 32'(f_in_service), 32'd0);
    check("flat_reti.req", 32'(fbus.irq_req), 32'd0);
    tick();
    check("flat_req0.req", 32'(fbus.irq_req), 32'd1);
    check("flat_req0.idx", 32'(fbus.irq_idx), 32'd0);
    check("flat_req0.vec", fbus.irq_vector, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised multi-channel interrupt controller that replaces the single-line interrupt entry path of the pipelined processor. It latches N_IRQ external requests (per-channel edge or level mode) and applies per-channel masks and fixed priority. It presents one request at a time to the fetch/interrupt-injection logic through a req/ack handshake, with a vector address. It tracks in-service channels so that an instruction-retired RETI ends service, and optionally allows higher-priority nesting.

## Interface
- N_IRQ, 4: number of interrupt channels (1..16).
- IDX_W, 2: width of the channel index; 2^IDX_W >= N_IRQ.
- NESTING, 1: 1 = a higher-priority channel may preempt an in-service one; 0 = no request while any channel is in service.
- VEC_BASE, 32'h0000_0010: vector address of channel 0.
- VEC_STRIDE, 32'h0000_0002: vector spacing between channels.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt lines.
- edge_mode  in  N_IRQ  per channel: 1 = rising-edge triggered, 0 = level.
- mask_in  in  N_IRQ  per channel: 1 = enabled.
- global_en  in  1  master interrupt enable.
- ack  in  1  fetch has accepted the presented request (injection sequence started).
- reti  in  1  one RETI has completed.
- irq_req  out  1  request to fetch.
- irq_idx  out  IDX_W  channel being requested.
- irq_vector  out  32  VEC_BASE + irq_idx*VEC_STRIDE.
- pending  out  N_IRQ  latched pending bits.
- in_service  out  N_IRQ  channels currently being serviced.
- busy  out  1  |in_service.

## Operation
- Edge capture: register irq_prev <= irq_in every cycle. Edge channel: pending[i] is set when irq_in[i] & ~irq_prev[i]. Level channel: pending[i] <= irq_in[i] every cycle.
- Edge-channel pending clears on ack for that channel. A new rising edge on the same channel in the same cycle wins, so pending stays set.
- Level channel: the ISR must deassert the source. The controller never re-requests a channel whose in_service bit is set.
- eligible = pending & mask_in & ~in_service, gated by global_en.
  - NESTING=1: additionally restricted to channels with index strictly lower than the lowest set in_service bit.
  - NESTING=0: eligible is forced to 0 while busy.
- Priority: lowest index wins.
- FSM, two states:
  - IDLE: irq_req=0. If eligible != 0, latch the winning index into sel_idx and go to REQ.
  - REQ: irq_req=1; irq_idx=sel_idx; irq_vector derived from sel_idx. All three are held stable until ack. The request is committed: later arrivals, mask changes or global_en=0 do not alter or withdraw it. On ack: set in_service[sel_idx], clear pending[sel_idx] if it is an edge channel, go to IDLE.
- ack in IDLE is ignored.
- reti clears the lowest-index set bit of in_service, evaluated on the pre-edge value. With in_service=0, reti is ignored. When reti and ack occur in the same cycle, the reti clear uses the old in_service and the ack set is then OR-ed in.
- Vector arithmetic is 32-bit modulo 2^32.

## Timing
- Reset values: irq_req=0, irq_idx=0, irq_vector=VEC_BASE, pending=0, in_service=0, busy=0, FSM=IDLE.
- During reset, irq_prev <= irq_in, so a line held high across reset release produces no edge.
- Latency: a line sampled high at edge E0 sets pending at E0. FSM enters REQ at E1, so irq_req is high in the cycle after E1. Idle-to-request latency is 2 cycles.
- ack is sampled at the edge while in REQ. irq_req is low the following cycle, and in_service/pending update at that same edge.
- There is a minimum 1 cycle of irq_req=0 between consecutive requests.
- Reset asserted mid-REQ or mid-service drops irq_req and clears all state at that edge.

## Test plan
- Single edge channel: N_IRQ=4, masks=4'b1111, global_en=1. Pulse irq_in[2] for 1 cycle -> irq_req high 2 cycles later, irq_idx=2, irq_vector=32'h14. ack -> in_service=4'b0100, pending=0, busy=1. reti -> in_service=0.
- Priority and masking: raise irq_in[3] and irq_in[1] in the same cycle with mask_in=4'b1101 -> request idx=3 only; pending[1] stays set. Unmask channel 1 after ack of 3 -> idx=1 requested (nesting, 1<3).
- Nesting off: NESTING=0, channel 2 in service, edge on channel 0 -> no irq_req until reti. Then idx=0 is requested 1 cycle after in_service clears.
- Committed request: in REQ with idx=2, raise irq_in[0] and drop global_en -> irq_idx stays 2 and irq_vector stays 32'h14 until ack.
- Same-cycle events: in_service=4'b0100, REQ idx=0; assert ack and reti together -> in_service=4'b0001. Edge on channel 0 coincident with ack -> pending[0] remains 1.
- Level channel and reset: edge_mode[1]=0, irq_in[1] held high across reset release -> no spurious edge on edge-mode channels. Channel 1 is requested once and not re-requested while in service. Assert reset during REQ -> irq_req=0 and all state cleared the next cycle.
